// File: rtl/rv_mem_stage.sv
// ---------------------------------------------------------------------------
// rv_mem_stage
//
// Memory-access stage that sits directly after the second ALU stage. Loads and
// stores go out on the data bus through a req/ack handshake. Every other
// instruction, and any instruction already marked for a trap, passes its ALU
// result straight through to writeback with one cycle of latency. While a bus
// access is in flight, o_ready is low so the upstream stage stalls.
//
// Parameters
//   DADDR_SPACE_BITS : width of the data bus address (truncated effective addr)
//   EXTENSION_Zicsr  : 1 forwards i_to_trap to o_to_trap, 0 ties it to zero
//
// Optional feature macro
//   RV_MEM_MISALIGN_TRAP_EN : when defined, a misaligned half or word access
//                             traps instead of going to the bus. When it is
//                             undefined, o_trap_misalign stays at 0 and the
//                             address is aligned down with no check.
//
// Ports
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_flush                 : pipeline flush
//   i_valid / o_ready       : upstream handshake
//   i_result, i_add         : ALU result, effective address
//   i_load, i_store         : access type
//   i_reg_write, i_rd       : destination register write enable / index
//   i_wdata, i_wsel         : lane-replicated store data, byte enables
//   i_funct3                : access size and sign (B/H/W/BU/HU)
//   i_to_trap               : trap already pending on this instruction
//   o_d_req .. o_d_wsel     : data bus request side
//   i_d_ack, i_d_rdata      : data bus response side
//   o_valid .. o_to_trap    : writeback entry
//   o_trap_misalign         : misaligned access flag
// ---------------------------------------------------------------------------
module rv_mem_stage #(
  parameter int DADDR_SPACE_BITS = 32,
  parameter int EXTENSION_Zicsr  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_flush,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [31:0]                 i_result,
  input  logic [31:0]                 i_add,
  input  logic                        i_load,
  input  logic                        i_store,
  input  logic                        i_reg_write,
  input  logic [4:0]                  i_rd,
  input  logic [31:0]                 i_wdata,
  input  logic [3:0]                  i_wsel,
  input  logic [2:0]                  i_funct3,
  input  logic                        i_to_trap,
  output logic                        o_d_req,
  output logic                        o_d_we,
  output logic [DADDR_SPACE_BITS-1:0] o_d_addr,
  output logic [31:0]                 o_d_wdata,
  output logic [3:0]                  o_d_wsel,
  input  logic                        i_d_ack,
  input  logic [31:0]                 i_d_rdata,
  output logic                        o_valid,
  output logic                        o_reg_write,
  output logic [4:0]                  o_rd,
  output logic [31:0]                 o_wb_data,
  output logic                        o_to_trap,
  output logic                        o_trap_misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic ZICSR_EN = (EXTENSION_Zicsr != 0);

  state_t      state;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic        store_q;
  logic        kill_q;

  logic        accept;
  logic        is_mem;
  logic        misalign;
  logic        kill_now;

  // Select the byte or half lane that the low address bits point at, then
  // sign- or zero-extend it. funct3[2] marks the unsigned variants, and
  // funct3[1:0] gives the size. Size code 2'b11 is not a legal load, so it
  // is treated as a full word.
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3[1:0])
      2'b00:   r = funct3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = funct3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign o_ready = (state == IDLE);
  assign accept  = i_valid & o_ready & ~i_flush;
  assign is_mem  = (i_load | i_store) & ~i_to_trap;

`ifdef RV_MEM_MISALIGN_TRAP_EN
  // A half access must have an even address, and a word access must have
  // bits [1:0] equal to zero. funct3[1] set means word (or the illegal 2'b11).
  assign misalign = (i_funct3[1:0] == 2'b01 && i_add[0]) ||
                    (i_funct3[1] && (i_add[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // If a flush arrives in the same cycle as the ack, the entry is killed in
  // the same way as a flush that arrived earlier in BUSY.
  assign kill_now = kill_q | i_flush;

  // Single state machine. All outputs toward writeback and the bus are
  // registered here. Once a bus access starts, it always runs to completion.
  // A flush only clears the writeback valid when DRAIN is reached.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      lane_q          <= 2'b00;
      funct3_q        <= 3'b000;
      rd_q            <= 5'd0;
      reg_write_q     <= 1'b0;
      store_q         <= 1'b0;
      kill_q          <= 1'b0;
      o_d_req         <= 1'b0;
      o_d_we          <= 1'b0;
      o_d_addr        <= '0;
      o_d_wdata       <= 32'h0;
      o_d_wsel        <= 4'h0;
      o_valid         <= 1'b0;
      o_reg_write     <= 1'b0;
      o_rd            <= 5'd0;
      o_wb_data       <= 32'h0;
      o_to_trap       <= 1'b0;
      o_trap_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mem && !misalign) begin
            state       <= BUSY;
            lane_q      <= i_add[1:0];
            funct3_q    <= i_funct3;
            rd_q        <= i_rd;
            reg_write_q <= i_reg_write;
            store_q     <= i_store;
            kill_q      <= 1'b0;
            o_d_req     <= 1'b1;
            o_d_we      <= i_store;
            o_d_addr    <= {i_add[DADDR_SPACE_BITS-1:2], 2'b00};
            o_d_wdata   <= i_wdata;
            o_d_wsel    <= i_store ? i_wsel : 4'b1111;
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_to_trap   <= 1'b0;
            o_trap_misalign <= 1'b0;
          end else if (accept && is_mem) begin
            o_valid         <= 1'b1;
            o_reg_write     <= 1'b0;
            o_rd            <= i_rd;
            o_wb_data       <= i_result;
            o_to_trap       <= ZICSR_EN;
            o_trap_misalign <= 1'b1;
          end else if (accept) begin
            o_valid         <= 1'b1;
            o_reg_write     <= i_reg_write & ~i_to_trap;
            o_rd            <= i_rd;
            o_wb_data       <= i_result;
            o_to_trap       <= ZICSR_EN & i_to_trap;
            o_trap_misalign <= 1'b0;
          end else begin
            o_valid         <= 1'b0;
            o_reg_write     <= 1'b0;
            o_to_trap       <= 1'b0;
            o_trap_misalign <= 1'b0;
          end
        end

        BUSY: begin
          o_valid     <= 1'b0;
          o_reg_write <= 1'b0;
          if (i_d_ack) begin
            state       <= DRAIN;
            o_d_req     <= 1'b0;
            kill_q      <= 1'b0;
            o_valid     <= ~kill_now;
            o_reg_write <= reg_write_q & ~store_q & ~kill_now;
            o_rd        <= rd_q;
            o_wb_data   <= store_q ? 32'h0 :
                           extend_load(i_d_rdata, lane_q, funct3_q);
            o_to_trap   <= 1'b0;
          end else if (i_flush) begin
            kill_q <= 1'b1;
          end
        end

        DRAIN: begin
          state       <= IDLE;
          o_valid     <= 1'b0;
          o_reg_write <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          o_d_req <= 1'b0;
          o_valid <= 1'b0;
          o_reg_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_mem_stage
//
// Directed testbench for rv_mem_stage. All expected values in this file were
// worked out by hand. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_rv_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_result;
  logic [31:0] i_add;
  logic        i_load;
  logic        i_store;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic [31:0] i_wdata;
  logic [3:0]  i_wsel;
  logic [2:0]  i_funct3;
  logic        i_to_trap;
  logic        o_d_req;
  logic        o_d_we;
  logic [31:0] o_d_addr;
  logic [31:0] o_d_wdata;
  logic [3:0]  o_d_wsel;
  logic        i_d_ack;
  logic [31:0] i_d_rdata;
  logic        o_valid;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic [31:0] o_wb_data;
  logic        o_to_trap;
  logic        o_trap_misalign;

  int checks = 0;
  int errors = 0;

  rv_mem_stage #(
    .DADDR_SPACE_BITS(32),
    .EXTENSION_Zicsr(1)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_result(i_result),
    .i_add(i_add),
    .i_load(i_load),
    .i_store(i_store),
    .i_reg_write(i_reg_write),
    .i_rd(i_rd),
    .i_wdata(i_wdata),
    .i_wsel(i_wsel),
    .i_funct3(i_funct3),
    .i_to_trap(i_to_trap),
    .o_d_req(o_d_req),
    .o_d_we(o_d_we),
    .o_d_addr(o_d_addr),
    .o_d_wdata(o_d_wdata),
    .o_d_wsel(o_d_wsel),
    .i_d_ack(i_d_ack),
    .i_d_rdata(i_d_rdata),
    .o_valid(o_valid),
    .o_reg_write(o_reg_write),
    .o_rd(o_rd),
    .o_wb_data(o_wb_data),
    .o_to_trap(o_to_trap),
    .o_trap_misalign(o_trap_misalign)
  );

  always #5 i_clk = ~i_clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Present one instruction to the stage with i_valid high.
  task automatic applyStimulus(input logic load, input logic store,
                               input logic [2:0] f3, input logic [31:0] add,
                               input logic [31:0] result, input logic [31:0] wdata,
                               input logic [3:0] wsel, input logic [4:0] rd,
                               input logic rw, input logic trap);
    i_valid     = 1'b1;
    i_load      = load;
    i_store     = store;
    i_funct3    = f3;
    i_add       = add;
    i_result    = result;
    i_wdata     = wdata;
    i_wsel      = wsel;
    i_rd        = rd;
    i_reg_write = rw;
    i_to_trap   = trap;
  endtask

  // Run a load with the given number of wait states and check the bus side
  // and the writeback side.
  task automatic runLoad(input string tag, input logic [31:0] add,
                         input logic [2:0] f3, input logic [31:0] rdata,
                         input int waits, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    applyStimulus(1'b1, 1'b0, f3, add, 32'h0, 32'h0, 4'h0, 5'd7, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    i_add   = 32'hFFFF_FFFF;
    for (int k = 0; k <= waits; k++) begin
      checkOutput({tag, "_req"}, o_d_req, 1);
      checkOutput({tag, "_addr"}, o_d_addr, exp_addr);
      checkOutput({tag, "_busy_valid"}, o_valid, 0);
      if (k == waits) begin
        i_d_ack   = 1'b1;
        i_d_rdata = rdata;
      end else begin
        i_d_rdata = ~rdata;
      end
      step();
    end
    i_d_ack = 1'b0;
    checkOutput({tag, "_valid"}, o_valid, 1);
    checkOutput({tag, "_data"}, o_wb_data, exp_data);
    checkOutput({tag, "_regwr"}, o_reg_write, 1);
    checkOutput({tag, "_rd"}, o_rd, 7);
    checkOutput({tag, "_req_drop"}, o_d_req, 0);
    checkOutput({tag, "_drain_ready"}, o_ready, 0);
    step();
    checkOutput({tag, "_ready_back"}, o_ready, 1);
    checkOutput({tag, "_valid_drop"}, o_valid, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_result = 32'h0;
    i_add = 32'h0; i_load = 1'b0; i_store = 1'b0; i_reg_write = 1'b0;
    i_rd = 5'd0; i_wdata = 32'h0; i_wsel = 4'h0; i_funct3 = 3'b000;
    i_to_trap = 1'b0; i_d_ack = 1'b0; i_d_rdata = 32'h0;
    step();
    step();
    checkOutput("rst_ready", o_ready, 1);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_req", o_d_req, 0);
    checkOutput("rst_regwr", o_reg_write, 0);
    checkOutput("rst_misalign", o_trap_misalign, 0);
    i_reset = 1'b0;
    step();

    // ALU pass-through
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 4'h0, 5'd5, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    checkOutput("alu_valid", o_valid, 1);
    checkOutput("alu_data", o_wb_data, 32'h1234_5678);
    checkOutput("alu_rd", o_rd, 5);
    checkOutput("alu_regwr", o_reg_write, 1);
    checkOutput("alu_req", o_d_req, 0);
    checkOutput("alu_ready", o_ready, 1);
    step();
    checkOutput("alu_valid_drop", o_valid, 0);

    // A trapping load bypasses the bus
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0000_00AB, 32'h0, 4'h0, 5'd9, 1'b1, 1'b1);
    step();
    i_valid = 1'b0;
    checkOutput("trap_valid", o_valid, 1);
    checkOutput("trap_regwr", o_reg_write, 0);
    checkOutput("trap_flag", o_to_trap, 1);
    checkOutput("trap_req", o_d_req, 0);
    checkOutput("trap_data", o_wb_data, 32'h0000_00AB);
    step();
    checkOutput("trap_flag_drop", o_to_trap, 0);

    // Loads: LB with 3 wait states, then zero-wait LHU/LH/LW/LBU
    runLoad("lb", 32'h1003, 3'b000, 32'h80FF_0000, 3, 32'h1000, 32'hFFFF_FF80);
    runLoad("lhu", 32'h2002, 3'b101, 32'hBEEF_1234, 0, 32'h2000, 32'h0000_BEEF);
    runLoad("lh", 32'h2002, 3'b001, 32'hBEEF_1234, 0, 32'h2000, 32'hFFFF_BEEF);
    runLoad("lw", 32'h2000, 3'b010, 32'hBEEF_1234, 0, 32'h2000, 32'hBEEF_1234);
    runLoad("lbu", 32'h2001, 3'b100, 32'hBEEF_1234, 1, 32'h2000, 32'h0000_0012);
    runLoad("lh_lo", 32'h2000, 3'b001, 32'h0000_8001, 0, 32'h2000, 32'hFFFF_8001);

    // Store byte
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h3001, 32'h0, 32'hAAAA_AAAA, 4'b0010, 5'd3, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    i_wsel  = 4'b1111;
    checkOutput("sb_req", o_d_req, 1);
    checkOutput("sb_we", o_d_we, 1);
    checkOutput("sb_wsel", o_d_wsel, 4'b0010);
    checkOutput("sb_addr", o_d_addr, 32'h3000);
    checkOutput("sb_wdata", o_d_wdata, 32'hAAAA_AAAA);
    i_d_ack = 1'b1;
    step();
    i_d_ack = 1'b0;
    checkOutput("sb_valid", o_valid, 1);
    checkOutput("sb_regwr", o_reg_write, 0);
    checkOutput("sb_req_drop", o_d_req, 0);
    step();

    // Flush in BUSY, ack arrives 2 cycles later
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 4'h0, 5'd4, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    i_flush = 1'b1;
    checkOutput("fl_req1", o_d_req, 1);
    step();
    i_flush = 1'b0;
    checkOutput("fl_req2", o_d_req, 1);
    step();
    checkOutput("fl_req3", o_d_req, 1);
    i_d_ack = 1'b1;
    i_d_rdata = 32'h1111_2222;
    step();
    i_d_ack = 1'b0;
    checkOutput("fl_valid", o_valid, 0);
    checkOutput("fl_regwr", o_reg_write, 0);
    checkOutput("fl_req_drop", o_d_req, 0);
    step();
    checkOutput("fl_ready", o_ready, 1);

    // Flush and ack in the same cycle
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h5004, 32'h0, 32'h0, 4'h0, 5'd4, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    i_flush = 1'b1;
    i_d_ack = 1'b1;
    step();
    i_flush = 1'b0;
    i_d_ack = 1'b0;
    checkOutput("flack_valid", o_valid, 0);
    checkOutput("flack_regwr", o_reg_write, 0);
    step();

    // A flush in IDLE blocks the accept, and an ack in IDLE is ignored
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h5555_5555, 32'h0, 4'h0, 5'd6, 1'b1, 1'b0);
    i_flush = 1'b1;
    i_d_ack = 1'b1;
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_d_ack = 1'b0;
    checkOutput("fli_valid", o_valid, 0);
    checkOutput("fli_regwr", o_reg_write, 0);
    checkOutput("fli_ready", o_ready, 1);
    checkOutput("fli_req", o_d_req, 0);

`ifdef RV_MEM_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h4002, 32'h0, 32'h0, 4'h0, 5'd8, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    checkOutput("mis_req", o_d_req, 0);
    checkOutput("mis_flag", o_trap_misalign, 1);
    checkOutput("mis_valid", o_valid, 1);
    checkOutput("mis_trap", o_to_trap, 1);
    checkOutput("mis_regwr", o_reg_write, 0);
    checkOutput("mis_ready", o_ready, 1);
    step();
    checkOutput("mis_flag_drop", o_trap_misalign, 0);
`else
    runLoad("lw_unal", 32'h4002, 3'b010, 32'hCAFE_F00D, 0, 32'h4000, 32'hCAFE_F00D);
    checkOutput("unal_misalign", o_trap_misalign, 0);
`endif

    // Reset in the middle of BUSY
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 32'h0, 4'h0, 5'd2, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    checkOutput("rstb_req", o_d_req, 1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checkOutput("rstb_req_drop", o_d_req, 0);
    checkOutput("rstb_valid", o_valid, 0);
    checkOutput("rstb_ready", o_ready, 1);
    step();
    checkOutput("rstb_req_stay", o_d_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
